// File: rtl/video_timing_gen.sv
// Raster timing generator: registered sync/enable/position decode from next-position
// counters, plus a re-timing delay line so *_d sync lines up with the downstream pipeline.
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int PIPE_DELAY = 4
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic        line_start,
  output logic        hsync_d,
  output logic        vsync_d,
  output logic        de_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS_W   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE_W   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST_W = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT_W  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS_W   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE_W   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST_W = 12'(V_TOTAL - 1);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: ~HS_ON, vs: ~VS_ON, de: 1'b0};

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  sync_t       sync_q, sync_d;
  logic        fs_q, fs_d;
  logic        ls_q, ls_d;
  logic        h_in_sync, v_in_sync;

  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    sync_d    = sync_q;
    fs_d      = 1'b0;
    ls_d      = 1'b0;
    h_in_sync = (h_cnt_q >= H_SS_W) && (h_cnt_q < H_SE_W);
    v_in_sync = (v_cnt_q >= V_SS_W) && (v_cnt_q < V_SE_W);
    if (enable) begin
      x_d       = h_cnt_q;
      y_d       = v_cnt_q;
      sync_d.de = (h_cnt_q < H_ACT_W) && (v_cnt_q < V_ACT_W);
      sync_d.hs = h_in_sync ? HS_ON : ~HS_ON;
      sync_d.vs = v_in_sync ? VS_ON : ~VS_ON;
      ls_d      = (h_cnt_q == 12'd0);
      fs_d      = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
      // End of frame wraps both counters in the same cycle.
      if (h_cnt_q == H_LAST_W) begin
        h_cnt_d = 12'd0;
        v_cnt_d = (v_cnt_q == V_LAST_W) ? 12'd0 : v_cnt_q + 12'd1;
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sync_q  <= SYNC_IDLE;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sync_q  <= sync_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
    end
  end

  assign hsync       = sync_q.hs;
  assign vsync       = sync_q.vs;
  assign de          = sync_q.de;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign hsync_d = sync_q.hs;
      assign vsync_d = sync_q.vs;
      assign de_d    = sync_q.de;
    end else begin : g_dly
      sync_t [PIPE_DELAY-1:0] dly_q, dly_d;

      // Shifts only on enabled edges so the delay tracks raster position, not time.
      always_comb begin
        dly_d = dly_q;
        if (enable) begin
          dly_d[0] = sync_q;
          for (int i = 1; i < PIPE_DELAY; i++) dly_d[i] = dly_q[i-1];
        end
      end

      always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) dly_q <= {PIPE_DELAY{SYNC_IDLE}};
        else          dly_q <= dly_d;
      end

      assign hsync_d = dly_q[PIPE_DELAY-1].hs;
      assign vsync_d = dly_q[PIPE_DELAY-1].vs;
      assign de_d    = dly_q[PIPE_DELAY-1].de;
    end
  endgenerate

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default 640x480 instance checked every cycle against a
// raster model via a scoreboard queue; a tiny-raster instance covers frame wrap.
module tb_video_timing_gen;

  logic        pixel_clk = 1'b0;
  logic        reset_n   = 1'b0;
  logic        enable    = 1'b0;

  logic        hsync, vsync, de, frame_start, line_start, hsync_d, vsync_d, de_d;
  logic [11:0] x, y;

  logic        hs_s, vs_s, de_s, fs_s, ls_s, hsd_s, vsd_s, ded_s;
  logic [11:0] x_s, y_s;

  always #5 pixel_clk = ~pixel_clk;

  video_timing_gen dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .enable(enable),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .line_start(line_start),
    .hsync_d(hsync_d), .vsync_d(vsync_d), .de_d(de_d)
  );

  // 15 x 10 raster, active-high syncs, no delay.
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .PIPE_DELAY(0)
  ) dut_s (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .enable(enable),
    .hsync(hs_s), .vsync(vs_s), .de(de_s), .x(x_s), .y(y_s),
    .frame_start(fs_s), .line_start(ls_s),
    .hsync_d(hsd_s), .vsync_d(vsd_s), .de_d(ded_s)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic        ls;
    logic        hsd;
    logic        vsd;
    logic        ded;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  int         mh, mv;
  exp_t       cur;
  logic [2:0] dl [4];

  function automatic void model_reset();
    mh = 0; mv = 0;
    cur = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: 12'd0, y: 12'd0, fs: 1'b0, ls: 1'b0,
            hsd: 1'b1, vsd: 1'b1, ded: 1'b0};
    for (int i = 0; i < 4; i++) dl[i] = 3'b110;
  endfunction

  function automatic void model_edge(input logic en);
    if (!en) begin
      cur.fs = 1'b0;
      cur.ls = 1'b0;
      return;
    end
    for (int i = 3; i > 0; i--) dl[i] = dl[i-1];
    dl[0]  = {cur.hs, cur.vs, cur.de};
    cur.x  = 12'(mh);
    cur.y  = 12'(mv);
    cur.de = (mh < 640) && (mv < 480);
    cur.hs = !((mh >= 656) && (mh < 752));
    cur.vs = !((mv >= 490) && (mv < 492));
    cur.ls = (mh == 0);
    cur.fs = (mh == 0) && (mv == 0);
    {cur.hsd, cur.vsd, cur.ded} = dl[3];
    if (mh == 799) begin
      mh = 0;
      mv = (mv == 524) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
  endfunction

  task automatic step();
    exp_t e, got;
    model_edge(enable);
    exp_q.push_back(cur);
    @(posedge pixel_clk);
    #1;
    got = '{hs: hsync, vs: vsync, de: de, x: x, y: y, fs: frame_start, ls: line_start,
            hsd: hsync_d, vsd: vsync_d, ded: de_d};
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL scoreboard got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b ls=%b d=%b%b%b, expected hs=%b vs=%b de=%b x=%0d y=%0d fs=%b ls=%b d=%b%b%b",
               got.hs, got.vs, got.de, got.x, got.y, got.fs, got.ls, got.hsd, got.vsd, got.ded,
               e.hs, e.vs, e.de, e.x, e.y, e.fs, e.ls, e.hsd, e.vsd, e.ded);
    end
  endtask

  task automatic do_reset();
    enable  = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge pixel_clk);
    #1;
    model_reset();
    exp_q.delete();
    reset_n = 1'b1;
    enable  = 1'b1;
  endtask

  task automatic run_until(input int tx, input int ty);
    int n = 0;
    while (!(x == 12'(tx) && y == 12'(ty)) && n < 5000) begin
      step();
      n++;
    end
    n_vec++;
    if (n >= 5000) begin
      n_err++;
      $display("FAIL run_until timeout at x=%0d y=%0d, required x=%0d y=%0d", x, y, tx, ty);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({hsync, vsync, de, x, y, frame_start, line_start, hsync_d, vsync_d, de_d} !==
        {1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_default hs=%b vs=%b de=%b x=%0d y=%0d fs=%b ls=%b d=%b%b%b, required idle",
               hsync, vsync, de, x, y, frame_start, line_start, hsync_d, vsync_d, de_d);
    end
    n_vec++;
    if ({hs_s, vs_s, de_s, fs_s, ls_s, hsd_s, vsd_s, ded_s} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_small got %b%b%b%b%b%b%b%b, required 00000000",
               hs_s, vs_s, de_s, fs_s, ls_s, hsd_s, vsd_s, ded_s);
    end
  endtask

  task automatic test_line();
    int de_cnt = 0, hs_cnt = 0, hs_first = -1;
    do_reset();
    step();
    n_vec++;
    if ({x, y, de, frame_start, line_start, hsync, vsync} !== {12'd0, 12'd0, 5'b11111}) begin
      n_err++;
      $display("FAIL first_pixel x=%0d y=%0d de=%b fs=%b ls=%b hs=%b vs=%b, required 0 0 1 1 1 1 1",
               x, y, de, frame_start, line_start, hsync, vsync);
    end
    for (int i = 0; i < 800; i++) begin
      if (i > 0) step();
      if (de) de_cnt++;
      if (!hsync) begin
        if (hs_first < 0) hs_first = int'(x);
        hs_cnt++;
      end
    end
    n_vec++;
    if (de_cnt != 640) begin
      n_err++; $display("FAIL line_de_count got %0d, required 640", de_cnt);
    end
    n_vec++;
    if (hs_cnt != 96 || hs_first != 656) begin
      n_err++; $display("FAIL line_hsync got width %0d start %0d, required 96 at 656", hs_cnt, hs_first);
    end
    step();
    n_vec++;
    if ({line_start, frame_start, x, y} !== {1'b1, 1'b0, 12'd0, 12'd1}) begin
      n_err++;
      $display("FAIL line_wrap ls=%b fs=%b x=%0d y=%0d, required ls=1 fs=0 x=0 y=1",
               line_start, frame_start, x, y);
    end
  endtask

  task automatic test_delay();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step();
      n_vec++;
      if ({hsync_d, vsync_d, de_d} !== ((i < 5) ? 3'b110 : 3'b111)) begin
        n_err++;
        $display("FAIL delay_fill cycle %0d got %b%b%b, required %b", i, hsync_d, vsync_d, de_d,
                 (i < 5) ? 3'b110 : 3'b111);
      end
    end
    run_until(660, 0);
    repeat (4) step();
    n_vec++;
    if ({hsync, hsync_d} !== 2'b00) begin
      n_err++; $display("FAIL delay_hsync got hs=%b hs_d=%b at x=%0d, required 0 0", hsync, hsync_d, x);
    end
  endtask

  task automatic test_enable_hold();
    run_until(0, 1);
    enable = 1'b0;
    step();
    n_vec++;
    if (line_start !== 1'b0 || x !== 12'd0) begin
      n_err++; $display("FAIL hold_ls got ls=%b x=%0d, required ls=0 x=0", line_start, x);
    end
    enable = 1'b1;
    run_until(100, 1);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (x !== 12'd100 || y !== 12'd1 || frame_start !== 1'b0 || line_start !== 1'b0) begin
        n_err++;
        $display("FAIL hold_freeze x=%0d y=%0d fs=%b ls=%b, required x=100 y=1 fs=0 ls=0",
                 x, y, frame_start, line_start);
      end
    end
    enable = 1'b1;
    step();
    n_vec++;
    if (x !== 12'd101) begin
      n_err++; $display("FAIL hold_resume x=%0d, required 101", x);
    end
  endtask

  task automatic test_frame();
    int de_c = 0, ded_c = 0, vs_c = 0, hs_c = 0, fs_c = 0, vs_bad = 0;
    logic [11:0] lx, ly;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      step();
      if (de_s) de_c++;
      if (ded_s) ded_c++;
      if (hs_s) hs_c++;
      if (fs_s) fs_c++;
      if (vs_s) begin
        vs_c++;
        if (y_s != 12'd7 && y_s != 12'd8) vs_bad++;
      end
      lx = x_s; ly = y_s;
    end
    n_vec++;
    if (de_c != 48 || ded_c != 48) begin
      n_err++; $display("FAIL frame_de got %0d/%0d, required 48", de_c, ded_c);
    end
    n_vec++;
    if (vs_c != 30 || vs_bad != 0 || hs_c != 30) begin
      n_err++;
      $display("FAIL frame_sync got vs=%0d (bad %0d) hs=%0d, required 30 (bad 0) 30", vs_c, vs_bad, hs_c);
    end
    n_vec++;
    if (fs_c != 1 || lx != 12'd14 || ly != 12'd9) begin
      n_err++; $display("FAIL frame_end got fs=%0d last=%0d,%0d, required 1 at 14,9", fs_c, lx, ly);
    end
    step();
    n_vec++;
    if ({fs_s, ls_s, x_s, y_s} !== {2'b11, 12'd0, 12'd0}) begin
      n_err++; $display("FAIL frame_wrap fs=%b ls=%b x=%0d y=%0d, required 1 1 0 0", fs_s, ls_s, x_s, y_s);
    end
  endtask

  task automatic test_reset_mid();
    run_until(50, 3);
    #3;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({hsync, vsync, de, x, y, frame_start, line_start, hsync_d, vsync_d, de_d} !==
        {1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset hs=%b vs=%b de=%b x=%0d y=%0d fs=%b ls=%b d=%b%b%b, required idle",
               hsync, vsync, de, x, y, frame_start, line_start, hsync_d, vsync_d, de_d);
    end
    do_reset();
    step();
    n_vec++;
    if ({x, y, frame_start, line_start} !== {12'd0, 12'd0, 2'b11}) begin
      n_err++;
      $display("FAIL reset_restart x=%0d y=%0d fs=%b ls=%b, required 0 0 1 1", x, y, frame_start, line_start);
    end
    step();
    n_vec++;
    if (x !== 12'd1 || y !== 12'd0) begin
      n_err++; $display("FAIL reset_next x=%0d y=%0d, required 1 0", x, y);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_line();
    test_delay();
    test_enable_hold();
    test_frame();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator for the ray-traced graphics path; sits directly upstream of the scene/camera stage.
- Produces pixel-clock-synchronous hsync, vsync, data-enable and pixel coordinates that drive the camera ray generator and the sphere intersection pipeline.
- A parameterised delay line re-times sync/enable to match the fixed latency of the downstream scene pipeline, so the video output stage receives sync aligned with pixel_data.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync/hsync_d (0 = active-low)
- VSYNC_POL, 0, active level of vsync/vsync_d
- PIPE_DELAY, 4, cycles of delay applied to the *_d outputs (0 allowed)

Ports:
- pixel_clk  input  1  pixel clock; all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  advance raster when 1; hold all state when 0
- hsync  output  1  horizontal sync, undelayed
- vsync  output  1  vertical sync, undelayed
- de  output  1  data enable (active region), undelayed
- x  output  12  current horizontal position, 0..H_TOTAL-1
- y  output  12  current line, 0..V_TOTAL-1
- frame_start  output  1  one-cycle pulse at x=0, y=0
- line_start  output  1  one-cycle pulse at x=0 of every line
- hsync_d  output  1  hsync delayed PIPE_DELAY cycles
- vsync_d  output  1  vsync delayed PIPE_DELAY cycles
- de_d  output  1  de delayed PIPE_DELAY cycles

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). Both must be ≤ 4096; counters are 12 bit.
- Internal state: next-position counters h_cnt, v_cnt.
- All outputs are registered from that state.

Reset (reset_n low, asynchronous):
- h_cnt = v_cnt = 0; x = y = 0.
- de = 0; frame_start = line_start = 0.
- hsync = ~HSYNC_POL; vsync = ~VSYNC_POL.
- Every delay-line stage is loaded with the same inactive values, so the *_d outputs reset to de_d = 0 and inactive sync.

Per rising edge with enable = 1:
- Outputs load the decode of (h_cnt, v_cnt):
  - x = h_cnt; y = v_cnt.
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync active iff H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync active iff V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, for the whole line including its blanking.
  - line_start = (h_cnt == 0); frame_start = (h_cnt == 0 && v_cnt == 0).
- Counters then advance:
  - h_cnt wraps H_TOTAL-1 → 0.
  - v_cnt increments only on that h wrap, and wraps V_TOTAL-1 → 0 in the same cycle.
- First enabled edge after reset release therefore presents x=0, y=0, de=1, frame_start=1, line_start=1.

enable = 0:
- Counters, undelayed outputs and delay line all hold, with no advance.
- frame_start and line_start are forced to 0 while held, so no pulse is duplicated.
- On re-enable, the raster resumes from the held position.

Delay line:
- PIPE_DELAY-stage shift register of {hsync, vsync, de}; shifts only when enable = 1.
- PIPE_DELAY = 0: *_d are wires equal to the undelayed outputs.

Other rules:
- Reset asserted mid-frame: immediate return to reset values; the next frame restarts at (0,0) with no partial-line output.
- Simultaneous h and v wrap, at the last pixel of the frame, is a single-cycle transition to (0,0).

Test Plan:
- Reset with defaults, then 1 enabled cycle → x=0, y=0, de=1, frame_start=1, line_start=1, hsync=1, vsync=1 (inactive-low).
- Run 800 cycles:
  - de high for exactly 640 cycles.
  - hsync low for exactly 96 cycles, starting at x=656.
  - line_start pulses again at cycle 800 with y=1.
- Run full frame of 420000 cycles:
  - vsync low for lines 490–491 (1600 cycles).
  - de count = 307200.
  - frame_start exactly once, and again at cycle 420000.
  - Last pixel x=799, y=524 is followed by x=0, y=0.
- PIPE_DELAY=4 → hsync_d/vsync_d/de_d equal hsync/vsync/de shifted exactly 4 cycles; before 4 enabled cycles after reset, de_d=0 with inactive sync.
- Deassert enable for 10 cycles at x=100 → all outputs frozen, no frame_start/line_start pulses; resume continues at x=101.
- Assert reset_n low asynchronously mid-frame (y=200) → outputs immediately take reset values; after release the first enabled cycle shows x=0, y=0, frame_start=1.
